// File: rtl/aes_mode_ctrl.sv
// ECB/CBC/CTR chaining controller wrapped around a single-block AES core.
// One block is in flight at a time; config and data use valid/ready handshakes.
module aes_mode_ctrl #(
    parameter int NB        = 4,
    parameter int NK        = 4,
    parameter int CTR_W     = 32,
    parameter bit RELOAD_IV = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [1:0]       cfg_mode,
    input  logic             cfg_dec,
    input  logic [32*NK-1:0] cfg_key,
    input  logic [32*NB-1:0] cfg_iv,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [32*NB-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [32*NB-1:0] out_data,
    output logic             out_last,
    output logic [32*NK-1:0] core_key,
    output logic [32*NB-1:0] core_data,
    output logic [1:0]       core_func,
    output logic             core_enable,
    input  logic [32*NB-1:0] core_result,
    input  logic             core_ready,
    output logic             busy
);

    localparam int BLK_W = 32 * NB;

    localparam logic [1:0] MODE_CBC  = 2'd1;
    localparam logic [1:0] MODE_CTR  = 2'd2;
    localparam logic [1:0] FUNC_KEYX = 2'd1;
    localparam logic [1:0] FUNC_ENC  = 2'd2;
    localparam logic [1:0] FUNC_DEC  = 2'd3;

    typedef enum logic [2:0] {S_IDLE, S_KEYX, S_READY, S_ISSUE, S_WAIT, S_OUT} state_t;

    state_t             state;
    logic [1:0]         mode;
    logic               dec;
    logic [BLK_W-1:0]   iv;
    logic [BLK_W-1:0]   chain;
    logic [BLK_W-1:0]   in_p0;
    logic               last_p0;
    logic               in_open;

    // Config always wins a same-cycle race with data, so data is masked by cfg_valid.
    assign in_ready = in_open & ~cfg_valid;

    function automatic logic [BLK_W-1:0] blk_operand(input logic [1:0] m, input logic d,
                                                     input logic [BLK_W-1:0] din,
                                                     input logic [BLK_W-1:0] ch);
        logic [BLK_W-1:0] r;
        case (m)
            MODE_CBC: r = d ? din : (din ^ ch);
            MODE_CTR: r = ch;
            default:  r = din;
        endcase
        return r;
    endfunction

    function automatic logic [1:0] blk_func(input logic [1:0] m, input logic d);
        return (m == MODE_CTR || !d) ? FUNC_ENC : FUNC_DEC;
    endfunction

    function automatic logic [BLK_W-1:0] blk_result(input logic [1:0] m, input logic d,
                                                    input logic [BLK_W-1:0] res,
                                                    input logic [BLK_W-1:0] din,
                                                    input logic [BLK_W-1:0] ch);
        logic [BLK_W-1:0] r;
        case (m)
            MODE_CBC: r = d ? (res ^ ch) : res;
            MODE_CTR: r = din ^ res;
            default:  r = res;
        endcase
        return r;
    endfunction

    // Counter field wraps silently; bits above CTR_W are never touched.
    function automatic logic [BLK_W-1:0] ctr_inc(input logic [BLK_W-1:0] c);
        logic [BLK_W-1:0] r;
        logic [CTR_W-1:0] lo;
        r  = c;
        lo = c[CTR_W-1:0] + CTR_W'(1);
        r[CTR_W-1:0] = lo;
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            mode        <= '0;
            dec         <= 1'b0;
            iv          <= '0;
            chain       <= '0;
            in_p0       <= '0;
            last_p0     <= 1'b0;
            in_open     <= 1'b0;
            cfg_ready   <= 1'b0;
            busy        <= 1'b0;
            core_key    <= '0;
            core_data   <= '0;
            core_func   <= '0;
            core_enable <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_last    <= 1'b0;
        end else begin
            core_enable <= 1'b0;
            case (state)
                S_IDLE, S_READY: begin
                    cfg_ready <= 1'b1;
                    in_open   <= (state == S_READY);
                    if (cfg_valid && cfg_ready) begin
                        mode        <= cfg_mode;
                        dec         <= cfg_dec;
                        iv          <= cfg_iv;
                        chain       <= cfg_iv;
                        core_key    <= cfg_key;
                        core_func   <= FUNC_KEYX;
                        core_enable <= 1'b1;
                        cfg_ready   <= 1'b0;
                        in_open     <= 1'b0;
                        busy        <= 1'b1;
                        state       <= S_KEYX;
                    end else if (in_valid && in_ready) begin
                        // Input stage: operand and function are registered here and held until core_ready.
                        in_p0       <= in_data;
                        last_p0     <= in_last;
                        core_data   <= blk_operand(mode, dec, in_data, chain);
                        core_func   <= blk_func(mode, dec);
                        core_enable <= 1'b1;
                        cfg_ready   <= 1'b0;
                        in_open     <= 1'b0;
                        busy        <= 1'b1;
                        state       <= S_ISSUE;
                    end
                end
                S_KEYX: begin
                    if (core_ready) begin
                        cfg_ready <= 1'b1;
                        in_open   <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_READY;
                    end
                end
                S_ISSUE: state <= S_WAIT;
                S_WAIT: begin
                    // Output stage: chaining applied to the core result, chain advanced for the next block.
                    if (core_ready) begin
                        out_data  <= blk_result(mode, dec, core_result, in_p0, chain);
                        out_last  <= last_p0;
                        out_valid <= 1'b1;
                        if (mode == MODE_CBC)
                            chain <= dec ? in_p0 : core_result;
                        else if (mode == MODE_CTR)
                            chain <= ctr_inc(chain);
                        state <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        cfg_ready <= 1'b1;
                        in_open   <= 1'b1;
                        busy      <= 1'b0;
                        if (out_last && RELOAD_IV)
                            chain <= iv;
                        state <= S_READY;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_mode_ctrl.sv
// Bench for aes_mode_ctrl: behavioural AES-128 core model plus SP800-38A / FIPS-197 vectors.
module tb_aes_mode_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         cfg_valid = 1'b0;
    logic         cfg_ready;
    logic [1:0]   cfg_mode = '0;
    logic         cfg_dec = 1'b0;
    logic [127:0] cfg_key = '0;
    logic [127:0] cfg_iv = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic         in_last = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] out_data;
    logic         out_last;
    logic [127:0] core_key;
    logic [127:0] core_data;
    logic [1:0]   core_func;
    logic         core_enable;
    logic [127:0] core_result;
    logic         core_ready;
    logic         busy;

    int checks = 0;
    int errors = 0;
    int core_lat = 3;
    logic [128:0] exp_q [$];

    aes_mode_ctrl dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_mode(cfg_mode), .cfg_dec(cfg_dec),
        .cfg_key(cfg_key), .cfg_iv(cfg_iv),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .core_key(core_key), .core_data(core_data), .core_func(core_func), .core_enable(core_enable),
        .core_result(core_result), .core_ready(core_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P0  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C0  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] IVC = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    localparam logic [127:0] E1  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;

    logic [127:0] pt [4] = '{128'h6bc1bee22e409f96e93d7e117393172a, 128'hae2d8a571e03ac9c9eb76fac45af8e51,
                             128'h30c81c46a35ce411e5fbc1191a0a52ef, 128'hf69f2445df4f9b17ad2b417be66c3710};
    logic [127:0] cbc [4] = '{128'h7649abac8119b246cee98e9b12e9197d, 128'h5086cb9b507219ee95db113a917678b2,
                              128'h73bed6b8e3c1743b7116e69e22229516, 128'h3ff1caa1681fac09120eca307586e1a7};
    logic [127:0] ctr [4] = '{128'h874d6191b620e3261bef6864990db6ce, 128'h9806f66b7970fdff8617187bb9fffdff,
                              128'h5ae4df3edbd5d35e5b4f09020db03eab, 128'h1e031dda2fbe03d1792170a0f3009cee};

    // ---------------- AES-128 reference ----------------
    logic [7:0] sbox [256];
    logic [7:0] isbox [256];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv, b;
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox[x]  = b;
            isbox[b] = 8'(x);
        end
    endtask

    function automatic logic [10:0][127:0] expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        logic [10:0][127:0] rk;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return rk;
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] p, input logic [127:0] k);
        logic [10:0][127:0] rk;
        logic [7:0] a [16];
        logic [7:0] b [16];
        logic [127:0] s;
        rk = expand(k);
        s = p ^ rk[0];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) a[i] = s[127-8*i -: 8];
            for (int c = 0; c < 4; c++)
                for (int j = 0; j < 4; j++) b[c*4+j] = sbox[a[((c+j)%4)*4+j]];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a[c*4+0] = gm(b[c*4], 8'h02) ^ gm(b[c*4+1], 8'h03) ^ b[c*4+2] ^ b[c*4+3];
                    a[c*4+1] = b[c*4] ^ gm(b[c*4+1], 8'h02) ^ gm(b[c*4+2], 8'h03) ^ b[c*4+3];
                    a[c*4+2] = b[c*4] ^ b[c*4+1] ^ gm(b[c*4+2], 8'h02) ^ gm(b[c*4+3], 8'h03);
                    a[c*4+3] = gm(b[c*4], 8'h03) ^ b[c*4+1] ^ b[c*4+2] ^ gm(b[c*4+3], 8'h02);
                end
            end else begin
                a = b;
            end
            for (int i = 0; i < 16; i++) s[127-8*i -: 8] = a[i];
            s = s ^ rk[r];
        end
        return s;
    endfunction

    function automatic logic [127:0] aes_dec(input logic [127:0] c_in, input logic [127:0] k);
        logic [10:0][127:0] rk;
        logic [7:0] a [16];
        logic [7:0] b [16];
        logic [127:0] s;
        rk = expand(k);
        s = c_in ^ rk[10];
        for (int r = 9; r >= 0; r--) begin
            for (int i = 0; i < 16; i++) a[i] = s[127-8*i -: 8];
            for (int c = 0; c < 4; c++)
                for (int j = 0; j < 4; j++) b[((c+j)%4)*4+j] = isbox[a[c*4+j]];
            for (int i = 0; i < 16; i++) s[127-8*i -: 8] = b[i];
            s = s ^ rk[r];
            if (r > 0) begin
                for (int i = 0; i < 16; i++) a[i] = s[127-8*i -: 8];
                for (int c = 0; c < 4; c++) begin
                    b[c*4+0] = gm(a[c*4], 8'h0e) ^ gm(a[c*4+1], 8'h0b) ^ gm(a[c*4+2], 8'h0d) ^ gm(a[c*4+3], 8'h09);
                    b[c*4+1] = gm(a[c*4], 8'h09) ^ gm(a[c*4+1], 8'h0e) ^ gm(a[c*4+2], 8'h0b) ^ gm(a[c*4+3], 8'h0d);
                    b[c*4+2] = gm(a[c*4], 8'h0d) ^ gm(a[c*4+1], 8'h09) ^ gm(a[c*4+2], 8'h0e) ^ gm(a[c*4+3], 8'h0b);
                    b[c*4+3] = gm(a[c*4], 8'h0b) ^ gm(a[c*4+1], 8'h0d) ^ gm(a[c*4+2], 8'h09) ^ gm(a[c*4+3], 8'h0e);
                end
                for (int i = 0; i < 16; i++) s[127-8*i -: 8] = b[i];
            end
        end
        return s;
    endfunction

    // ---------------- core model: L-cycle latency, request must be held ----------------
    int           cnt = 0;
    logic [1:0]   pf = '0;
    logic [127:0] pd = '0;
    logic [127:0] ck = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt = 0;
            core_ready  <= 1'b0;
            core_result <= '0;
        end else begin
            core_ready <= 1'b0;
            if (cnt > 0 && pf != 2'd1) begin
                checks++;
                if (core_data !== pd || core_func !== pf) begin
                    errors++;
                    $display("FAIL core_hold data=%h func=%0d required data=%h func=%0d", core_data, core_func, pd, pf);
                end
            end
            if (core_enable) begin
                checks++;
                if (cnt != 0) begin
                    errors++;
                    $display("FAIL core_overlap enable while busy, remaining=%0d required 0", cnt);
                end
                pf = core_func;
                pd = core_data;
                if (core_func == 2'd1) ck = core_key;
                cnt = core_lat;
            end
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    core_ready  <= 1'b1;
                    core_result <= (pf == 2'd2) ? aes_enc(pd, ck) : (pf == 2'd3) ? aes_dec(pd, ck) : '0;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_cfg(input logic [1:0] m, input logic d, input logic [127:0] k, input logic [127:0] v);
        int n;
        n = 0;
        while (!cfg_ready && n < 50) begin @(negedge clk); n++; end
        cfg_valid = 1'b1; cfg_mode = m; cfg_dec = d; cfg_key = k; cfg_iv = v;
        @(negedge clk);
        cfg_valid = 1'b0;
        n = 0;
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL cfg_timeout in_ready=%b required 1 after config", in_ready);
        end
    endtask

    task automatic xfer(input logic [127:0] d, input logic l, output logic [127:0] od, output logic ol, output int lat);
        int n;
        in_valid = 1'b1; in_data = d; in_last = l;
        n = 0;
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
        if (lat >= 100) begin
            checks++; errors++;
            $display("FAIL out_timeout out_valid=%b required 1", out_valid);
        end
        od = out_data;
        ol = out_last;
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({cfg_ready, in_ready, out_valid, out_last, busy, core_enable, core_func, out_data, core_data, core_key} !== '0) begin
            errors++;
            $display("FAIL reset_outputs cfg_ready=%b in_ready=%b out_valid=%b busy=%b core_enable=%b required all 0",
                     cfg_ready, in_ready, out_valid, busy, core_enable);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({cfg_ready, in_ready, busy} !== 3'b100) begin
            errors++;
            $display("FAIL idle_flags cfg_ready=%b in_ready=%b busy=%b required 1 0 0", cfg_ready, in_ready, busy);
        end
    endtask

    task automatic test_ecb();
        logic [127:0] od; logic ol; int lat; logic [128:0] e;
        core_lat = 3;
        do_cfg(2'd0, 1'b0, K1, '0);
        exp_q.push_back({1'b1, C0});
        xfer(P0, 1'b1, od, ol, lat);
        e = exp_q.pop_front();
        checks++;
        if ({ol, od} !== e) begin errors++; $display("FAIL ecb_enc got %h last %b required %h last %b", od, ol, e[127:0], e[128]); end
        checks++;
        if (lat != core_lat + 2) begin errors++; $display("FAIL ecb_latency got %0d required %0d", lat, core_lat + 2); end
        do_cfg(2'd0, 1'b1, K1, '0);
        exp_q.push_back({1'b0, P0});
        xfer(C0, 1'b0, od, ol, lat);
        e = exp_q.pop_front();
        checks++;
        if ({ol, od} !== e) begin errors++; $display("FAIL ecb_dec got %h last %b required %h last %b", od, ol, e[127:0], e[128]); end
        do_cfg(2'd3, 1'b0, K2, '0);
        exp_q.push_back({1'b1, E1});
        xfer(pt[0], 1'b1, od, ol, lat);
        e = exp_q.pop_front();
        checks++;
        if ({ol, od} !== e) begin errors++; $display("FAIL mode3_as_ecb got %h required %h", od, e[127:0]); end
    endtask

    task automatic test_cbc();
        logic [127:0] od; logic ol; int lat; logic [128:0] e;
        core_lat = 3;
        do_cfg(2'd1, 1'b0, K2, K1);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({i == 3, cbc[i]});
            xfer(pt[i], i == 3, od, ol, lat);
            e = exp_q.pop_front();
            checks++;
            if ({ol, od} !== e) begin errors++; $display("FAIL cbc_enc blk%0d got %h last %b required %h last %b", i, od, ol, e[127:0], e[128]); end
        end
        core_lat = 5;
        do_cfg(2'd1, 1'b1, K2, K1);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({i == 3, pt[i]});
            xfer(cbc[i], i == 3, od, ol, lat);
            e = exp_q.pop_front();
            checks++;
            if ({ol, od} !== e) begin errors++; $display("FAIL cbc_dec blk%0d got %h last %b required %h last %b", i, od, ol, e[127:0], e[128]); end
        end
    endtask

    task automatic test_ctr();
        logic [127:0] od; logic ol; int lat; logic [128:0] e;
        core_lat = 1;
        do_cfg(2'd2, 1'b0, K2, IVC);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({i == 3, ctr[i]});
            xfer(pt[i], i == 3, od, ol, lat);
            e = exp_q.pop_front();
            checks++;
            if ({ol, od} !== e) begin errors++; $display("FAIL ctr blk%0d got %h last %b required %h last %b", i, od, ol, e[127:0], e[128]); end
            if (i == 0) begin
                checks++;
                if (lat != 3) begin errors++; $display("FAIL ctr_latency got %0d required 3", lat); end
            end
        end
        core_lat = 3;
    endtask

    task automatic test_ctr_wrap();
        logic [127:0] od; logic ol; int lat; logic [128:0] e;
        logic [127:0] ivw, cb, d;
        ivw = 128'h0011223344556677_8899aabb_ffffffff;
        do_cfg(2'd2, 1'b1, K2, ivw);
        for (int i = 0; i < 3; i++) begin
            d  = {$urandom, $urandom, $urandom, $urandom};
            cb = {ivw[127:32], (i == 0) ? 32'hffffffff : 32'(i - 1)};
            exp_q.push_back({1'b0, d ^ aes_enc(cb, K2)});
            xfer(d, 1'b0, od, ol, lat);
            e = exp_q.pop_front();
            checks++;
            if ({ol, od} !== e) begin errors++; $display("FAIL ctr_wrap blk%0d got %h required %h", i, od, e[127:0]); end
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] od; logic ol; int lat, n; logic [128:0] e;
        do_cfg(2'd1, 1'b0, K2, K1);
        out_ready = 1'b0;
        exp_q.push_back({1'b1, cbc[0]});
        in_valid = 1'b1; in_data = pt[0]; in_last = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin @(negedge clk); n++; end
        e = exp_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({out_valid, out_last, in_ready, busy, cfg_ready, out_data} !== {1'b1, e[128], 1'b0, 1'b1, 1'b0, e[127:0]}) begin
                errors++;
                $display("FAIL stall_cycle%0d valid=%b last=%b in_ready=%b busy=%b cfg_ready=%b data=%h required 1 1 0 1 0 %h",
                         i, out_valid, out_last, in_ready, busy, cfg_ready, out_data, e[127:0]);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_release out_valid=%b required 0", out_valid); end
        exp_q.push_back({1'b1, cbc[0]});
        xfer(pt[0], 1'b1, od, ol, lat);
        e = exp_q.pop_front();
        checks++;
        if ({ol, od} !== e) begin errors++; $display("FAIL reload_iv got %h required %h", od, e[127:0]); end
        exp_q.push_back({1'b0, cbc[0]});
        exp_q.push_back({1'b1, cbc[1]});
        for (int i = 0; i < 2; i++) begin
            xfer(pt[i], i == 1, od, ol, lat);
            e = exp_q.pop_front();
            checks++;
            if ({ol, od} !== e) begin errors++; $display("FAIL chain_persist blk%0d got %h required %h", i, od, e[127:0]); end
        end
    endtask

    task automatic test_cfg_priority();
        logic [127:0] od; logic ol; int lat; logic [128:0] e;
        cfg_valid = 1'b1; cfg_mode = 2'd0; cfg_dec = 1'b0; cfg_key = K1; cfg_iv = '0;
        in_valid = 1'b1; in_data = P0; in_last = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL cfg_priority in_ready=%b required 0", in_ready); end
        @(negedge clk);
        cfg_valid = 1'b0;
        checks++;
        if ({busy, cfg_ready} !== 2'b10) begin errors++; $display("FAIL cfg_busy busy=%b cfg_ready=%b required 1 0", busy, cfg_ready); end
        exp_q.push_back({1'b1, C0});
        xfer(P0, 1'b1, od, ol, lat);
        e = exp_q.pop_front();
        checks++;
        if ({ol, od} !== e) begin errors++; $display("FAIL cfg_then_data got %h required %h", od, e[127:0]); end
    endtask

    task automatic test_reset_wait();
        logic [127:0] od; logic ol; int lat, n; logic [128:0] e;
        core_lat = 4;
        do_cfg(2'd0, 1'b0, K1, '0);
        in_valid = 1'b1; in_data = P0; in_last = 1'b0;
        n = 0;
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({cfg_ready, in_ready, out_valid, out_last, busy, core_enable, core_func, out_data, core_data, core_key} !== '0) begin
            errors++;
            $display("FAIL reset_in_wait cfg_ready=%b out_valid=%b busy=%b core_func=%0d core_data=%h required all 0",
                     cfg_ready, out_valid, busy, core_func, core_data);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b1; in_data = P0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if ({in_ready, out_valid} !== 2'b00) begin
                errors++;
                $display("FAIL post_reset_idle cycle%0d in_ready=%b out_valid=%b required 0 0", i, in_ready, out_valid);
            end
        end
        in_valid = 1'b0;
        do_cfg(2'd0, 1'b0, K1, '0);
        exp_q.push_back({1'b0, C0});
        xfer(P0, 1'b0, od, ol, lat);
        e = exp_q.pop_front();
        checks++;
        if ({ol, od} !== e) begin errors++; $display("FAIL after_reset_block got %h required %h", od, e[127:0]); end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        build_sbox();
        test_reset();
        test_ecb();
        test_cbc();
        test_ctr();
        test_ctr_wrap();
        test_backpressure();
        test_cfg_priority();
        test_reset_wait();
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
